// File: rtl/static_axil_master.sv
// static_axil_master
//   Turns a simple command/response handshake into single AXI4-Lite reads and
//   writes. Every bus transaction is guarded by a timeout. The first timeout
//   latches the sticky 'dead' flag. From then on, every command receives an
//   immediate SLVERR/timeout response and no bus activity is generated.
//
// Ports
//   CLK_IN_250, AXI_RESET_N        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_wr/addr/wdata/wstrb        : command payload (1 = write)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata/rsp_resp/rsp_timeout : response payload
//   dead                           : sticky, set by the first timeout
//   M_AXI_LITE_*                   : AXI4-Lite master port (AW, W, B, AR, R)
module static_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        CLK_IN_250,
    input  logic        AXI_RESET_N,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        dead,

    output logic [31:0] M_AXI_LITE_AWADDR,
    output logic [2:0]  M_AXI_LITE_AWPROT,
    output logic        M_AXI_LITE_AWVALID,
    input  logic        M_AXI_LITE_AWREADY,
    output logic [31:0] M_AXI_LITE_WDATA,
    output logic [3:0]  M_AXI_LITE_WSTRB,
    output logic        M_AXI_LITE_WVALID,
    input  logic        M_AXI_LITE_WREADY,
    input  logic [1:0]  M_AXI_LITE_BRESP,
    input  logic        M_AXI_LITE_BVALID,
    output logic        M_AXI_LITE_BREADY,
    output logic [31:0] M_AXI_LITE_ARADDR,
    output logic [2:0]  M_AXI_LITE_ARPROT,
    output logic        M_AXI_LITE_ARVALID,
    input  logic        M_AXI_LITE_ARREADY,
    input  logic [31:0] M_AXI_LITE_RDATA,
    input  logic [1:0]  M_AXI_LITE_RRESP,
    input  logic        M_AXI_LITE_RVALID,
    output logic        M_AXI_LITE_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP,
        DEAD
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_rst_done;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [15:0] r_cnt;
    logic        r_dead;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_rsp_timeout;

    logic        w_cmd_acc;
    logic        w_busy;
    logic        w_expire;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_req_done;
    logic        w_b_hs;
    logic        w_r_hs;
    logic        w_abort;

    assign w_cmd_acc  = cmd_valid & cmd_ready;
    assign w_busy     = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                        (r_state == RD_REQ) || (r_state == RD_RESP);
    assign w_expire   = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_aw_hs    = M_AXI_LITE_AWVALID & M_AXI_LITE_AWREADY;
    assign w_w_hs     = M_AXI_LITE_WVALID & M_AXI_LITE_WREADY;
    // Address and data phases may complete in either order, or in the same cycle.
    assign w_req_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_b_hs     = M_AXI_LITE_BVALID & M_AXI_LITE_BREADY;
    assign w_r_hs     = M_AXI_LITE_RVALID & M_AXI_LITE_RREADY;
    // A B/R handshake in the expiry cycle takes priority over the timeout.
    assign w_abort    = w_busy & w_expire & ~w_b_hs & ~w_r_hs;

    // State register
    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_acc) begin
                    w_next = cmd_wr ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (w_abort) begin
                    w_next = RSP;
                end else if (w_req_done) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_b_hs || w_abort) begin
                    w_next = RSP;
                end
            end
            RD_REQ: begin
                if (w_abort) begin
                    w_next = RSP;
                end else if (w_aw_hs || (M_AXI_LITE_ARVALID && M_AXI_LITE_ARREADY)) begin
                    w_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (w_r_hs || w_abort) begin
                    w_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_next = r_dead ? DEAD : IDLE;
                end
            end
            DEAD: begin
                if (w_cmd_acc) begin
                    w_next = RSP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        M_AXI_LITE_AWVALID = 1'b0;
        M_AXI_LITE_WVALID  = 1'b0;
        M_AXI_LITE_BREADY  = 1'b0;
        M_AXI_LITE_ARVALID = 1'b0;
        M_AXI_LITE_RREADY  = 1'b0;
        unique case (r_state)
            IDLE:    cmd_ready = r_rst_done;
            DEAD:    cmd_ready = r_rst_done;
            WR_REQ: begin
                M_AXI_LITE_AWVALID = ~r_aw_done;
                M_AXI_LITE_WVALID  = ~r_w_done;
            end
            WR_RESP: M_AXI_LITE_BREADY  = 1'b1;
            RD_REQ:  M_AXI_LITE_ARVALID = 1'b1;
            RD_RESP: M_AXI_LITE_RREADY  = 1'b1;
            RSP:     rsp_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Keeps cmd_ready low until the first edge after reset is released.
    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Command capture, phase tracking, timeout counter and response payload
    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) begin
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_cnt         <= '0;
            r_dead        <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_wr      <= cmd_wr;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_cnt     <= '0;
                if (r_state == DEAD) begin
                    // Dead: answer at once without touching the bus.
                    r_rsp_resp    <= 2'b10;
                    r_rsp_timeout <= 1'b1;
                    r_rsp_rdata   <= cmd_wr ? '0 : TIMEOUT_RDATA;
                end
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end

            if (w_b_hs) begin
                r_rsp_resp    <= M_AXI_LITE_BRESP;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b0;
            end
            if (w_r_hs) begin
                r_rsp_resp    <= M_AXI_LITE_RRESP;
                r_rsp_rdata   <= M_AXI_LITE_RDATA;
                r_rsp_timeout <= 1'b0;
            end

            if (w_abort) begin
                r_rsp_resp    <= 2'b10;
                r_rsp_timeout <= 1'b1;
                r_rsp_rdata   <= r_wr ? '0 : TIMEOUT_RDATA;
                r_dead        <= 1'b1;
            end
        end
    end

    assign rsp_rdata          = r_rsp_rdata;
    assign rsp_resp           = r_rsp_resp;
    assign rsp_timeout        = r_rsp_timeout;
    assign dead               = r_dead;

    assign M_AXI_LITE_AWADDR  = r_addr;
    assign M_AXI_LITE_AWPROT  = 3'b000;
    assign M_AXI_LITE_WDATA   = r_wdata;
    assign M_AXI_LITE_WSTRB   = r_wstrb;
    assign M_AXI_LITE_ARADDR  = r_addr;
    assign M_AXI_LITE_ARPROT  = 3'b000;

endmodule
